// File: rtl/conv_pkg.sv
// Shared defaults, window layout and feeder FSM states for the convolution datapath.
package conv_pkg;

    localparam int N_DEFAULT = 32;
    localparam int Q_DEFAULT = 15;
    localparam int K_DEFAULT = 3;

    // Element r*K+c is row r, column c; element 0 is the oldest (top-left) pixel.
    typedef logic [K_DEFAULT*K_DEFAULT-1:0][N_DEFAULT-1:0] window_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/line_buffer.sv
// Single-clock delay line: each enabled push returns the word pushed DEPTH pushes earlier.
module line_buffer #(
    parameter int N     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] ptr;

    // The slot about to be overwritten holds the word from one full row ago.
    assign dout = mem[ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Turns a raster pixel stream into K x K sliding windows for the MACC array, with
// ready/valid flow control on both sides and one frame armed per start pulse.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int N           = N_DEFAULT,
    parameter int Q           = Q_DEFAULT,
    parameter int ARRAY_WIDTH = K_DEFAULT,
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      s_valid,
    input  logic [N-1:0]                              s_data,
    output logic                                      s_ready,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [ARRAY_WIDTH*ARRAY_WIDTH-1:0][N-1:0] m_window,
    output logic                                      busy,
    output logic                                      frame_done
);

    localparam int K  = ARRAY_WIDTH;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

    // Q only labels the fixed-point format of the words; data passes untouched.
    if (Q >= N) begin : g_bad_q
        $error("conv_window_feeder: Q must be smaller than N");
    end

    state_t               state;
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [K*K-1:0][N-1:0] win_sr;
    logic [K*K-1:0][N-1:0] win_next;
    logic [N-1:0]         lb_in  [K-1];
    logic [N-1:0]         lb_out [K-1];
    logic                 accept;
    logic                 win_done;
    logic                 last_pix;

    assign s_ready  = ((state == FILL) || (state == RUN)) && (!m_valid || m_ready);
    assign accept   = s_valid && s_ready;
    assign win_done = accept && (col >= COL_WIN) && (row >= ROW_WIN);
    assign last_pix = accept && (col == COL_LAST) && (row == ROW_LAST);

    // Chained line buffers: buffer j outputs the pixel from j+1 rows above.
    for (genvar j = 0; j < K - 1; j++) begin : g_lb
        if (j == 0) begin : g_head
            assign lb_in[j] = s_data;
        end else begin : g_chain
            assign lb_in[j] = lb_out[j-1];
        end

        line_buffer #(
            .N     (N),
            .DEPTH (IMG_W)
        ) u_line_buffer (
            .clk  (clk),
            .rst  (rst),
            .en   (accept),
            .din  (lb_in[j]),
            .dout (lb_out[j])
        );
    end

    // Shift every row one column left and insert the new column tap on the right.
    always_comb begin
        win_next = win_sr >> N;
        win_next[K*K-1] = s_data;
        for (int j = 0; j < K - 1; j++) begin
            win_next[(K-2-j)*K + K-1] = lb_out[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            win_sr     <= '0;
            m_window   <= '0;
            m_valid    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (accept) begin
                win_sr <= win_next;
                if (col == COL_LAST) begin
                    col <= '0;
                    if (row != ROW_LAST) begin
                        row <= row + RW'(1);
                    end
                end else begin
                    col <= col + CW'(1);
                end
            end

            // A fresh window may replace the one being accepted in the same cycle.
            if (win_done) begin
                m_window <= win_next;
                m_valid  <= 1'b1;
            end else if (m_ready) begin
                m_valid  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FILL;
                        busy  <= 1'b1;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                FILL: begin
                    if (last_pix) begin
                        state <= DRAIN;
                    end else if (accept && (row == ROW_WIN)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (last_pix) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!m_valid) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed and randomized frames for conv_window_feeder, checked against a window model
// computed straight from the image array.
module tb_conv_window_feeder;
    import conv_pkg::*;

    localparam int N    = 32;
    localparam int K    = 3;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int WW   = K * K * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          s_valid;
    logic [N-1:0]  s_data;
    logic          s_ready;
    logic          m_valid;
    logic          m_ready;
    window_t       m_window;
    logic          busy;
    logic          frame_done;

    int            total = 0;
    int            bad   = 0;
    logic [N-1:0]  img [NPIX];
    window_t       exp_q [$];

    conv_window_feeder #(
        .N           (N),
        .Q           (15),
        .ARRAY_WIDTH (K),
        .IMG_W       (W),
        .IMG_H       (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_window   (m_window),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [WW-1:0] observed, input logic [WW-1:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Every valid KxK placement in raster order, read straight out of the image.
    task automatic buildExpected();
        window_t w;
        exp_q.delete();
        for (int wr = 0; wr <= H - K; wr++) begin
            for (int wc = 0; wc <= W - K; wc++) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        w[r*K + c] = img[(wr + r)*W + wc + c];
                    end
                end
                exp_q.push_back(w);
            end
        end
    endtask

    // mode 0: steady; 1: 5-cycle stall at first window; 2: bursty input;
    // 3: random valid/ready; 4: start held high during the frame.
    task automatic applyStimulus(input int mode);
        int      pix = 0;
        int      cycles = 0;
        int      stall = 0;
        int      done_cnt = 0;
        bit      armed = 0;
        bit      hold = 0;
        bit      mv_due = 0;
        bit      valid_now;
        window_t held;
        window_t w;

        buildExpected();
        m_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        while ((pix < NPIX || exp_q.size() > 0) && cycles < 300) begin
            @(negedge clk);
            cycles++;
            start = (mode == 4) && (pix < NPIX);
            checkOutput("busy_in_frame", busy, 1'b1);
            checkOutput("no_early_done", frame_done, 1'b0);
            if (hold) begin
                checkOutput("hold_window", m_window, held);
                checkOutput("hold_valid", m_valid, 1'b1);
            end
            if (mv_due) checkOutput("window_latency", m_valid, 1'b1);
            if (mode == 1 && m_valid && !armed) begin
                armed = 1;
                stall = 5;
            end
            case (mode)
                1: begin
                    m_ready = (stall == 0);
                    if (stall > 0) stall--;
                end
                3: m_ready = ($urandom_range(0, 2) != 0);
                default: m_ready = 1'b1;
            endcase
            case (mode)
                2: valid_now = (cycles % 2 == 1);
                3: valid_now = ($urandom_range(0, 1) == 1);
                default: valid_now = 1'b1;
            endcase
            if (pix < NPIX) begin
                s_valid = valid_now;
                s_data  = img[pix];
            end else begin
                s_valid = ($urandom_range(0, 1) == 1);
                s_data  = $urandom;
            end
            #1;
            checkOutput("s_ready", s_ready, (pix < NPIX) && (!m_valid || m_ready));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("no_extra_window", m_valid, 1'b0);
                end else begin
                    w = exp_q.pop_front();
                    checkOutput("window", m_window, w);
                end
            end
            hold = m_valid && !m_ready;
            held = m_window;
            mv_due = 0;
            if (s_valid && s_ready && pix < NPIX) begin
                mv_due = ((pix % W) >= K - 1) && ((pix / W) >= K - 1);
                pix++;
            end
        end
        checkOutput("pixels_sent", pix, NPIX);
        checkOutput("windows_left", exp_q.size(), 0);

        start   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (frame_done) done_cnt++;
        end
        checkOutput("frame_done_pulses", done_cnt, 1);
        checkOutput("end_busy", busy, 1'b0);
        checkOutput("end_m_valid", m_valid, 1'b0);
    endtask

    initial begin
        int done_cnt;

        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        #2;
        checkOutput("reset_m_valid", m_valid, 1'b0);
        checkOutput("reset_m_window", m_window, '0);
        checkOutput("reset_s_ready", s_ready, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_frame_done", frame_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] basic frame");
        for (int i = 0; i < NPIX; i++) img[i] = N'(i + 1);
        applyStimulus(0);

        $display("[TB] backpressure at first window");
        applyStimulus(1);

        $display("[TB] bursty input");
        applyStimulus(2);

        $display("[TB] reset mid-frame");
        m_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            s_data = N'(i + 1);
            @(negedge clk);
        end
        s_valid = 1'b0;
        rst = 1'b1;
        #2;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_m_valid", m_valid, 1'b0);
        checkOutput("abort_s_ready", s_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (frame_done) done_cnt++;
        end
        checkOutput("abort_no_frame_done", done_cnt, 0);
        for (int i = 0; i < NPIX; i++) img[i] = N'(101 + i);
        applyStimulus(0);

        $display("[TB] protocol guards");
        s_valid = 1'b1;
        s_data  = N'(999);
        repeat (4) begin
            @(negedge clk);
            checkOutput("idle_s_ready", s_ready, 1'b0);
            checkOutput("idle_m_valid", m_valid, 1'b0);
            checkOutput("idle_busy", busy, 1'b0);
        end
        s_valid = 1'b0;
        for (int i = 0; i < NPIX; i++) img[i] = N'(i + 1);
        applyStimulus(4);

        $display("[TB] random frames");
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NPIX; i++) img[i] = $urandom;
            applyStimulus(3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
